// File: rtl/hammu_pkg.sv
// Shared constants and types for the hammu_ip power engine.
// Optional feature macro: HAMMU_OVF_EN (sticky overflow flag in DONE bit1).
package hammu_pkg;

  localparam int X_W = 8;
  localparam int A_W = 4;
  localparam int P_W = 15;

  // Word indices, compared against address bits [4:2]
  localparam logic [2:0] OFF_X     = 3'd0;
  localparam logic [2:0] OFF_A     = 3'd1;
  localparam logic [2:0] OFF_START = 3'd2;
  localparam logic [2:0] OFF_P     = 3'd3;
  localparam logic [2:0] OFF_DONE  = 3'd4;

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

endpackage

// File: rtl/hammu_core.sv
// Iterative X^A mod 2^15 engine, one multiply per clock.
// Optional feature macro: HAMMU_OVF_EN adds the sticky ovf output.
module hammu_core
  import hammu_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [X_W-1:0] x,
  input  logic [A_W-1:0] a,
  output logic [P_W-1:0] p,
  output logic           done,
  output logic           busy
`ifdef HAMMU_OVF_EN
  ,
  output logic           ovf
`endif
);

  state_e             state_q, state_d;
  logic [X_W-1:0]     base_q, base_d;
  logic [A_W-1:0]     cnt_q, cnt_d;
  logic [P_W-1:0]     acc_q, acc_d, p_q, p_d;
  logic               done_q, done_d;
  logic [P_W+X_W-1:0] prod;

  assign prod = {{X_W{1'b0}}, acc_q} * {{P_W{1'b0}}, base_q};

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    p_d     = p_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (start) begin
        base_d  = x;
        cnt_d   = a;
        acc_d   = P_W'(1);
        done_d  = 1'b0;
        state_d = CALC;
      end
      CALC: if (cnt_q == '0) begin
        // Result and done are published on the edge that enters FIN
        p_d     = acc_q;
        done_d  = 1'b1;
        state_d = FIN;
      end else begin
        acc_d = prod[P_W-1:0];
        cnt_d = cnt_q - A_W'(1);
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  assign p    = p_q;
  assign done = done_q;
  assign busy = (state_q != IDLE);

`ifdef HAMMU_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && start)
      ovf_d = 1'b0;
    else if (state_q == CALC && cnt_q != '0 && (|prod[P_W+X_W-1:P_W]))
      ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[P_W+X_W-1:P_W];
`endif

endmodule

// File: rtl/hammu_ip.sv
// AXI4-Lite register front end for the hammu_core power engine.
// Optional feature macro: HAMMU_OVF_EN (DONE bit1 = sticky overflow).
module hammu_ip
  import hammu_pkg::*;
(
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic [31:0] S_AXI_AWADDR,
  input  logic        S_AXI_AWVALID,
  output logic        S_AXI_AWREADY,
  input  logic [31:0] S_AXI_WDATA,
  input  logic [3:0]  S_AXI_WSTRB,
  input  logic        S_AXI_WVALID,
  output logic        S_AXI_WREADY,
  output logic        S_AXI_BVALID,
  input  logic        S_AXI_BREADY,
  output logic [1:0]  S_AXI_BRESP,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  output logic [1:0]  S_AXI_RRESP
);

  logic           wrdy_q, bvalid_q, arready_q, rvalid_q, start_q;
  logic [31:0]    rdata_q, rdata_d;
  logic [X_W-1:0] x_q;
  logic [A_W-1:0] a_q;
  logic [P_W-1:0] p;
  logic           done, busy, wr_en, rd_en;
`ifdef HAMMU_OVF_EN
  logic           ovf;
`endif

  assign wr_en = wrdy_q && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en = arready_q && S_AXI_ARVALID;

  always_comb begin
    rdata_d = '0;
    case (S_AXI_ARADDR[4:2])
      OFF_X:     rdata_d[X_W-1:0] = x_q;
      OFF_A:     rdata_d[A_W-1:0] = a_q;
      OFF_START: rdata_d[0]       = busy | start_q;
      OFF_P:     rdata_d[P_W-1:0] = p;
      OFF_DONE: begin
        rdata_d[0] = done;
`ifdef HAMMU_OVF_EN
        rdata_d[1] = ovf;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      wrdy_q    <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      start_q   <= 1'b0;
      x_q       <= '0;
      a_q       <= '0;
    end else begin
      start_q   <= 1'b0;
      wrdy_q    <= !wrdy_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
      arready_q <= !arready_q && S_AXI_ARVALID && !rvalid_q;

      if (wr_en) begin
        bvalid_q <= 1'b1;
        if (S_AXI_WSTRB[0]) begin
          case (S_AXI_AWADDR[4:2])
            OFF_X:     x_q <= S_AXI_WDATA[X_W-1:0];
            OFF_A:     a_q <= S_AXI_WDATA[A_W-1:0];
            OFF_START: start_q <= S_AXI_WDATA[0] && !busy && !start_q;
            default: ;
          endcase
        end
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end

      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (rvalid_q && S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  hammu_core u_core (
    .clk   (S_AXI_ACLK),
    .rst   (S_AXI_ARESET),
    .start (start_q),
    .x     (x_q),
    .a     (a_q),
    .p     (p),
    .done  (done),
    .busy  (busy)
`ifdef HAMMU_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  assign S_AXI_AWREADY = wrdy_q;
  assign S_AXI_WREADY  = wrdy_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWADDR[31:5], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[31:5], S_AXI_ARADDR[1:0],
                         S_AXI_WDATA[31:X_W], S_AXI_WSTRB[3:1]};

endmodule

// File: tb/tb_hammu_ip.sv
// Directed bench for hammu_ip: register access, results, latency, busy and reset behaviour.
module tb_hammu_ip;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  hammu_ip dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_BRESP(bresp),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .S_AXI_RRESP(rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int ncmp = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic axi_wr(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output int hs);
    logic seen;
    seen = 1'b0; hs = 0;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (awready && wready) begin seen = 1'b1; hs = cyc; end
    end
    chk("wr_hs", seen, 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_bvalid", {bvalid, bresp}, 3'b100);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_rd(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] rs);
    logic seen;
    seen = 1'b0;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (arready) seen = 1'b1;
    end
    chk("rd_hs", seen, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    chk("rd_rvalid", rvalid, 1);
    d = rdata; rs = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] d;
    logic [1:0]  rs;
    d = '0;
    for (int i = 0; i < 40 && !d[0]; i++) axi_rd(32'h10, d, rs);
    chk(tag, d[0], 1);
  endtask

  task automatic run(input logic [7:0] x, input logic [3:0] a, output logic [31:0] p,
                     output logic [31:0] dn);
    int hs;
    logic [1:0] rs;
    axi_wr(32'h00, {24'h0, x}, 4'hF, hs);
    axi_wr(32'h04, {28'h0, a}, 4'hF, hs);
    axi_wr(32'h08, 32'h1, 4'hF, hs);
    wait_done("run_done");
    axi_rd(32'h10, dn, rs);
    axi_rd(32'h0C, p, rs);
  endtask

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  rs;
    int hs, dcyc;
    logic got;

    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = '0; arvalid = 0; rready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valids", {awready, wready, bvalid, arready, rvalid}, 5'b0);
    rst = 1'b0;
    axi_rd(32'h00, d, rs); chk("rst_x", d, 0);
    axi_rd(32'h04, d, rs); chk("rst_a", d, 0);
    axi_rd(32'h0C, d, rs); chk("rst_p", d, 0);
    axi_rd(32'h10, d, rs); chk("rst_done", d, 0);

    // 2^2 after a fixed 100 ns wait
    axi_wr(32'h00, 32'd2, 4'hF, hs);
    axi_wr(32'h04, 32'd2, 4'hF, hs);
    axi_wr(32'h08, 32'd1, 4'hF, hs);
    #100;
    axi_rd(32'h10, d, rs); chk("p22_done", d[0], 1);
    axi_rd(32'h0C, d, rs); chk("p22_p", d, 4);

    // 3^5 with latency measured from the START handshake
    axi_wr(32'h00, 32'd3, 4'hF, hs);
    axi_wr(32'h04, 32'd5, 4'hF, hs);
    axi_wr(32'h08, 32'd1, 4'hF, hs);
    got = 1'b0; dcyc = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(posedge clk); #1;
      if (dut.u_core.done) begin got = 1'b1; dcyc = cyc; end
    end
    chk("p35_seen", got, 1);
    chk("p35_lat", dcyc - hs, 8);
    axi_rd(32'h0C, d, rs); chk("p35_p", d, 243);

    run(8'd7, 4'd0, d, d2);   chk("a0_p", d, 1);
    run(8'd0, 4'd4, d, d2);   chk("x0_p", d, 0);
    run(8'd255, 4'd15, d, d2); chk("max_p", d, 3839);
`ifdef HAMMU_OVF_EN
    chk("max_done", d2, 3);
`else
    chk("max_done", d2, 1);
`endif

    // Operand and START writes during a run must not disturb it
    axi_wr(32'h00, 32'd3, 4'hF, hs);
    axi_wr(32'h04, 32'd12, 4'hF, hs);
    axi_wr(32'h08, 32'd1, 4'hF, hs);
    axi_rd(32'h08, d, rs); chk("busy_rd", d, 1);
    axi_wr(32'h00, 32'd9, 4'hF, hs);
    axi_wr(32'h08, 32'd1, 4'hF, hs);
    wait_done("busy_done");
    axi_rd(32'h0C, d, rs); chk("busy_p", d, 7153);
    axi_rd(32'h00, d, rs); chk("busy_x", d, 9);
    axi_rd(32'h08, d, rs); chk("idle_rd", d, 0);

    // Byte strobes, unused bits, base-address don't-care, unmapped offset
    axi_wr(32'h00, 32'h55, 4'h0, hs);
    axi_rd(32'h00, d, rs); chk("strb0_x", d, 9);
    axi_wr(32'h04, 32'hFFFF_FFFF, 4'hF, hs);
    axi_rd(32'h04, d, rs); chk("a_mask", d, 32'hF);
    axi_rd(32'h4000_000C, d, rs); chk("base_p", d, 7153);
    axi_rd(32'h14, d, rs); chk("unmap_d", d, 0); chk("unmap_resp", rs, 0);

    // Reset during CALC, then a clean run
    axi_wr(32'h00, 32'd3, 4'hF, hs);
    axi_wr(32'h04, 32'd12, 4'hF, hs);
    axi_wr(32'h08, 32'd1, 4'hF, hs);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_valids", {awready, wready, bvalid, arready, rvalid}, 5'b0);
    rst = 1'b0;
    axi_rd(32'h0C, d, rs); chk("mrst_p", d, 0);
    axi_rd(32'h10, d, rs); chk("mrst_done", d, 0);
    axi_rd(32'h00, d, rs); chk("mrst_x", d, 0);
    run(8'd2, 4'd3, d, d2); chk("post_p", d, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
